wheel_direction_detector: RTL and testbench

- Front end for the bogey counter: turns two raw track-side wheel sensors (A upstream, B downstream) into single-cycle a2b / b2a wheel-passage pulses.
- Synchronises, optionally debounces, and tracks each wheel through the A -> AB -> B sequence or its reverse. Only complete traversals emit a pulse; reversals mid-sensor and illegal patterns do not.
- Drives the a2b/b2a inputs of the bogey counter directly on the same Clk.

---
 rtl/track_pkg.sv | 21 ++
 rtl/sensor_debounce.sv | 61 ++++++
 rtl/wheel_direction_detector.sv | 148 ++++++++++++++
 tb/tb_wheel_direction_detector.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/track_pkg.sv
// Shared types for the wheel direction detector.
// FSM state encoding and the {fa, fb} sensor pattern constants.
package track_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A1,
        A2,
        A3,
        B1,
        B2,
        B3,
        ERR
    } state_t;

    localparam logic [1:0] S_NONE = 2'b00;
    localparam logic [1:0] S_A    = 2'b10;
    localparam logic [1:0] S_B    = 2'b01;
    localparam logic [1:0] S_AB   = 2'b11;

endpackage

// File: rtl/sensor_debounce.sv
// Per-sensor synchroniser with an optional stability filter.
// The filter is built only when DEBOUNCE_EN is defined.
module sensor_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic filt
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

`ifdef DEBOUNCE_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    logic [NS-1:0] sync_q;
    logic          sync_out;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NS-2:0], raw};
        end
    end

    assign sync_out = sync_q[NS-1];

    if (FILTER_ON && (DEB_CYCLES > 0)) begin : g_filt
        localparam int CW = $clog2(DEB_CYCLES + 1);
        localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

        logic [CW-1:0] cnt;
        logic          q;

        // Flip only after DEB_CYCLES consecutive disagreeing samples.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                q   <= 1'b0;
                cnt <= '0;
            end else if (sync_out == q) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                q   <= sync_out;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign filt = q;
    end else begin : g_thru
        assign filt = sync_out;
    end

endmodule

// File: rtl/wheel_direction_detector.sv
// Turns sensors A/B into a2b / b2a wheel-passage pulses.
// Define DEBOUNCE_EN to insert the per-sensor stability filter.
module wheel_direction_detector
    import track_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic sens_a,
    input  logic sens_b,
    output logic a2b,
    output logic b2a,
    output logic busy,
    output logic err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          fa;
    logic          fb;
    logic [1:0]    s;
    logic [1:0]    s_q;
    logic [TW-1:0] tcnt;
    logic          timeout;
    state_t        state;
    state_t        state_nx;

    sensor_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_a (
        .Clk  (Clk),
        .Reset(Reset),
        .raw  (sens_a),
        .filt (fa)
    );

    sensor_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_b (
        .Clk  (Clk),
        .Reset(Reset),
        .raw  (sens_b),
        .filt (fb)
    );

    assign s = {fa, fb};

    assign timeout = (state != IDLE) && (state != ERR) &&
                     (tcnt == T_LAST);

    always_comb begin
        state_nx = state;
        if (timeout) begin
            state_nx = ERR;
        end else begin
            unique case (state)
                IDLE: case (s)
                    S_A:     state_nx = A1;
                    S_B:     state_nx = B1;
                    S_AB:    state_nx = ERR;
                    default: ;
                endcase
                A1: case (s)
                    S_NONE:  state_nx = IDLE;
                    S_AB:    state_nx = A2;
                    S_B:     state_nx = ERR;
                    default: ;
                endcase
                A2: case (s)
                    S_B:     state_nx = A3;
                    S_A:     state_nx = A1;
                    S_NONE:  state_nx = ERR;
                    default: ;
                endcase
                A3: case (s)
                    S_NONE:  state_nx = IDLE;
                    S_AB:    state_nx = A2;
                    S_A:     state_nx = ERR;
                    default: ;
                endcase
                B1: case (s)
                    S_NONE:  state_nx = IDLE;
                    S_AB:    state_nx = B2;
                    S_A:     state_nx = ERR;
                    default: ;
                endcase
                B2: case (s)
                    S_A:     state_nx = B3;
                    S_B:     state_nx = B1;
                    S_NONE:  state_nx = ERR;
                    default: ;
                endcase
                B3: case (s)
                    S_NONE:  state_nx = IDLE;
                    S_AB:    state_nx = B2;
                    S_B:     state_nx = ERR;
                    default: ;
                endcase
                ERR: if (s == S_NONE) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Stall timer: only runs while a wheel is mid-sequence and s is static.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s_q  <= S_NONE;
            tcnt <= '0;
        end else begin
            s_q <= s;
            if ((state == IDLE) || (state == ERR) || (s != s_q)) begin
                tcnt <= '0;
            end else if (tcnt != T_LAST) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a2b  <= 1'b0;
            b2a  <= 1'b0;
            err  <= 1'b0;
            busy <= 1'b0;
        end else begin
            a2b  <= (state == A3) && (state_nx == IDLE);
            b2a  <= (state == B3) && (state_nx == IDLE);
            err  <= (state_nx == ERR) && (state != ERR);
            busy <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_wheel_direction_detector.sv
// Randomised and directed bench for wheel_direction_detector.
// Reference model walks a wheel along the A/AB/B pattern ladder.
module tb_wheel_direction_detector;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int TMO  = 50;
`ifdef DEBOUNCE_EN
    localparam int FLAT = DEB;
`else
    localparam int FLAT = 0;
`endif
    localparam int LAT = SYNC + FLAT + 1;

    // Forward pattern order of one wheel; reverse wheels use swapped bits.
    localparam logic [1:0] SEQ [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};

    logic Clk    = 1'b0;
    logic Reset  = 1'b1;
    logic sens_a = 1'b0;
    logic sens_b = 1'b0;
    logic a2b;
    logic b2a;
    logic busy;
    logic err;

    wheel_direction_detector #(
        .SYNC_STAGES   (SYNC),
        .DEB_CYCLES    (DEB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .sens_a(sens_a),
        .sens_b(sens_b),
        .a2b   (a2b),
        .b2a   (b2a),
        .busy  (busy),
        .err   (err)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_a2b = 0;
    int n_b2a = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [1:0] hist [$];
    logic [1:0] mf = 2'b00;
    int         dc [2];
    int         p = 0;
    bit         dir = 1'b0;
    bit         in_err = 1'b0;
    logic [1:0] m_sq = 2'b00;
    int         cyc = 0;
    int         anchor = 0;
    bit         m_a2b = 1'b0;
    bit         m_b2a = 1'b0;
    bit         m_err = 1'b0;
    bit         m_busy = 1'b0;

    always @(posedge Clk) begin
        logic [1:0] s;
        logic [1:0] sn;
        logic [1:0] sy;
        bit act;
        bit to;
        bit clr;
        if (Reset) begin
            hist = {};
            for (int i = 0; i < SYNC; i++) hist.push_back(2'b00);
            mf = 2'b00;
            dc[0] = 0;
            dc[1] = 0;
            p = 0;
            in_err = 1'b0;
            m_sq = 2'b00;
            anchor = cyc + 1;
            m_a2b = 1'b0;
            m_b2a = 1'b0;
            m_err = 1'b0;
            m_busy = 1'b0;
        end else begin
            sy = hist[SYNC-1];
`ifdef DEBOUNCE_EN
            s = mf;
`else
            s = sy;
`endif
            act = (p != 0) && !in_err;
            to  = act && ((cyc - anchor) == TMO - 1);
            clr = !act || (s != m_sq);
            m_a2b = 1'b0;
            m_b2a = 1'b0;
            m_err = 1'b0;
            if (to) begin
                in_err = 1'b1;
                p = 0;
                m_err = 1'b1;
            end else if (in_err) begin
                if (s == 2'b00) in_err = 1'b0;
            end else if (p == 0) begin
                if (s == 2'b10) begin
                    dir = 1'b0;
                    p = 1;
                end else if (s == 2'b01) begin
                    dir = 1'b1;
                    p = 1;
                end else if (s == 2'b11) begin
                    in_err = 1'b1;
                    m_err = 1'b1;
                end
            end else begin
                sn = dir ? {s[0], s[1]} : s;
                if (sn == SEQ[p+1]) begin
                    p++;
                    if (p == 4) begin
                        p = 0;
                        if (dir) m_b2a = 1'b1;
                        else m_a2b = 1'b1;
                    end
                end else if (sn == SEQ[p-1]) begin
                    p--;
                end else if (sn != SEQ[p]) begin
                    in_err = 1'b1;
                    p = 0;
                    m_err = 1'b1;
                end
            end
            m_busy = (p != 0) || in_err;
            if (clr) anchor = cyc + 1;
            m_sq = s;
`ifdef DEBOUNCE_EN
            for (int i = 0; i < 2; i++) begin
                if (sy[i] != mf[i]) begin
                    dc[i]++;
                    if (dc[i] == DEB) begin
                        mf[i] = sy[i];
                        dc[i] = 0;
                    end
                end else begin
                    dc[i] = 0;
                end
            end
`endif
            hist.push_front({sens_a, sens_b});
            void'(hist.pop_back());
        end
        cyc++;
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("a2b", a2b, m_a2b);
            check("b2a", b2a, m_b2a);
            check("err", err, m_err);
            check("busy", busy, m_busy);
            if (a2b) n_a2b++;
            if (b2a) n_b2a++;
            if (err) n_err++;
        end
    end

    task automatic hold(input logic a, input logic b, input int n);
        sens_a = a;
        sens_b = b;
        repeat (n) @(negedge Clk);
    endtask

    task automatic fwd_pass();
        hold(1'b1, 1'b0, 12);
        hold(1'b1, 1'b1, 12);
        hold(1'b0, 1'b1, 12);
        hold(1'b0, 1'b0, 16);
    endtask

    initial begin
        int a0;
        int b0;
        int e0;
        int lat;
        bit busy_seen;

        repeat (2) @(negedge Clk);
        check("rst_a2b", a2b, 1'b0);
        check("rst_b2a", b2a, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        Reset = 1'b0;
        chk_en = 1'b1;

        // Clean forward wheel with latency measurement
        a0 = n_a2b; b0 = n_b2a; e0 = n_err;
        hold(1'b1, 1'b0, 20);
        hold(1'b1, 1'b1, 20);
        hold(1'b0, 1'b1, 20);
        sens_b = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if (a2b && (lat < 0)) lat = i;
        end
        check("fwd_lat", lat, LAT);
        check("fwd_a2b", n_a2b - a0, 1);
        check("fwd_b2a", n_b2a - b0, 0);
        check("fwd_err", n_err - e0, 0);

        // Four clean reverse wheels
        a0 = n_a2b; b0 = n_b2a; e0 = n_err;
        for (int k = 0; k < 4; k++) begin
            hold(1'b0, 1'b1, 10);
            hold(1'b1, 1'b1, 10);
            hold(1'b1, 1'b0, 10);
            hold(1'b0, 1'b0, 15);
            check("rev_busy", busy, 1'b0);
        end
        check("rev_b2a", n_b2a - b0, 4);
        check("rev_a2b", n_a2b - a0, 0);
        check("rev_err", n_err - e0, 0);

        // Wheel backs out after reaching both sensors
        a0 = n_a2b; b0 = n_b2a; e0 = n_err;
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 15);
        check("bk_pulses", (n_a2b - a0) + (n_b2a - b0), 0);
        check("bk_err", n_err - e0, 0);
        check("bk_busy", busy, 1'b0);

        // A jumps straight to B: no overlap phase
        a0 = n_a2b; b0 = n_b2a; e0 = n_err;
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b1, 10);
        check("ill_err", n_err - e0, 1);
        check("ill_busy", busy, 1'b1);
        hold(1'b0, 1'b0, 15);
        check("ill_pulses", (n_a2b - a0) + (n_b2a - b0), 0);
        check("ill_idle", busy, 1'b0);
        fwd_pass();
        check("ill_then_fwd", n_a2b - a0, 1);

        // Two-cycle spike on A
        a0 = n_a2b; b0 = n_b2a; e0 = n_err;
        hold(1'b1, 1'b0, 2);
        sens_a = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            busy_seen |= busy;
        end
        check("gl_busy", busy_seen, (FLAT == 0));
        check("gl_pulses", (n_a2b - a0) + (n_b2a - b0), 0);
        check("gl_err", n_err - e0, 0);

        // A held past the stall limit
        a0 = n_a2b; b0 = n_b2a; e0 = n_err;
        hold(1'b1, 1'b0, TMO + 15);
        check("to_err", n_err - e0, 1);
        check("to_busy", busy, 1'b1);
        hold(1'b0, 1'b0, 15);
        check("to_idle", busy, 1'b0);
        check("to_pulses", (n_a2b - a0) + (n_b2a - b0), 0);

        // Reset while the wheel sits on B only
        a0 = n_a2b;
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("rs_a2b", a2b, 1'b0);
        check("rs_busy", busy, 1'b0);
        check("rs_err", err, 1'b0);
        hold(1'b0, 1'b0, 15);
        check("rs_no_a2b", n_a2b - a0, 0);

        // Random sensor activity against the ladder model
        for (int k = 0; k < 300; k++) begin
            int n;
            n = ($urandom_range(0, 19) == 0) ? TMO + 10
                                             : int'($urandom_range(1, 8));
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n);
        end
        hold(1'b0, 1'b0, 20);
        check("rnd_idle", busy, 1'b0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
